wrr_arbiter: RTL and testbench
==============================

// Module: wrr_arbiter
// PURPOSE
//   Weighted round-robin arbiter for N requesters with per-requester burst credits.
//   A granted requester keeps the grant for up to weight[i] accepted beats.
//   A beat is accepted only in a cycle where the downstream ready is high.
//   Sits in front of a shared resource (bus/port) that accepts one beat per ready cycle.
//   Successor to the single-grant round-robin arbiter: adds weights, ready backpressure,
//   a registered encoded grant index and back-to-back regrant.
// PARAMETERS
//   N   4  number of requesters (>=2)
//   WW  3  width of each weight field; weight 0 is treated as 1
// PORTS
//   clk        in   1      clock; all logic on posedge
//   rst        in   1      reset, synchronous, active-high
//   req        in   N      request per requester; level, held while wanting service
//   weight     in   N*WW   weight[i] = weight[i*WW +: WW]; sampled only at grant time
//   ready      in   1      downstream accepts a beat this cycle
//   gnt        out  N      one-hot grant, registered
//   gnt_valid  out  1      |gnt, registered
//   gnt_idx    out  $clog2(N)  binary index of owner; 0 when gnt_valid=0
// BEHAVIOUR
//   State
//   - Regs: state {IDLE,GRANT}, owner idx o, ptr (highest-priority idx), cnt (WW bits).
//   - Reset (rst=1 at posedge): state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, cnt=0.
//   - rst overrides everything, including mid-burst; no state survives.
//   Selection
//   - sel = first i with req[i]=1, scanning ptr, ptr+1, .. N-1, 0, .. ptr-1 (circular).
//   - Load: o=sel, gnt<=onehot(sel), cnt<=max(weight[sel],1), state=GRANT.
//   IDLE
//   - If |req: perform Load. The grant is visible the cycle after req is seen (latency 1).
//   - Otherwise stay IDLE.
//   GRANT
//   - beat = gnt[o] & req[o] & ready. On a beat, cnt decrements.
//   - Release occurs when either:
//     - req[o]=0 (dropped mid-burst; no beat is counted), or
//     - a beat occurs with cnt==1 (credit exhausted).
//   - On release:
//     - ptr<=(o+1) mod N; selection for this cycle uses the updated ptr.
//     - If any req is high (req[o] included, at lowest priority): Load in the same edge,
//       i.e. back-to-back with no idle bubble.
//     - Else gnt<=0 and state=IDLE.
//   - ready=0: no beat; cnt, gnt and ptr hold indefinitely, with no timeout.
//   - Weight changes while granted are ignored until the next Load.
//   - Other requesters' req changes while granted do not preempt the owner.
//   - A sole requester is regranted continuously, with cnt reloaded each release.
//   Invariants
//   - gnt is zero or one-hot; gnt_idx matches gnt.
//   - No requester waits more than sum of the other requesters' credits beats while ready=1.
// TESTING  (N=4, WW=3)
//   1. rst=1 for 2 clks with req=1111 -> gnt=0000, gnt_valid=0, gnt_idx=0 throughout.
//   2. req=0010, weight=2, ready=1 -> gnt=0010 one clk later; stays 0010 continuously.
//   3. req=1111, weights {3:1, 2:3, 1:2, 0:1}, ready=1 -> gnt 0001, 0010 x2, 0100 x3,
//      1000, 0001 ..., repeating with no 0000 gaps.
//   4. Owner 0100 with cnt=3, ready=0 for 5 clks -> gnt stays 0100, cnt stays 3;
//      then ready=1 -> 3 more beats, then the grant moves to next requester.
//   5. Owner 0010 weight 4; req[1] drops after 1 beat with req=1001 -> next clk gnt=1000;
//      after its credit, gnt=0001 (wrap 3->0).
//   6. weight[0]=0, req=0001 -> release and regrant every beat (cnt loads 1);
//      assert rst mid-burst -> next clk gnt=0000, ptr=0.

Source files
------------

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters and the weighted arbiter.
// The arbiter side uses the slave modport.
interface wrr_arbiter_if #(
  parameter int N  = 4,
  parameter int WW = 3
);
  localparam int IW = $clog2(N);

  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic            ready;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [IW-1:0]   gnt_idx;

  modport master (
    output req,
    output weight,
    output ready,
    input  gnt,
    input  gnt_valid,
    input  gnt_idx
  );

  modport slave (
    input  req,
    input  weight,
    input  ready,
    output gnt,
    output gnt_valid,
    output gnt_idx
  );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: the owner holds the grant for up to
// weight[i] ready-qualified beats, then hands off with no idle bubble.
module wrr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 3
) (
  input logic      clk,
  input logic      rst,
  wrr_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [WW-1:0] cnt, cnt_nx;
  logic [N-1:0]  gnt, gnt_nx;
  logic          valid, valid_nx;

  logic [IW-1:0] next_o;
  logic [IW-1:0] base;
  logic [IW-1:0] sel;
  logic [WW-1:0] wsel;
  logic          any_req;
  logic          beat;
  logic          rel;

  // Circular scan from b; lowest offset wins.
  function automatic logic [IW-1:0] pick(
    input logic [N-1:0]  r,
    input logic [IW-1:0] b
  );
    logic [IW-1:0] p;
    int            j;
    p = b;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(b) + k;
      if (j >= N) j = j - N;
      if (r[j]) p = IW'(j);
    end
    return p;
  endfunction

  always_comb begin
    next_o  = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
    any_req = |bus.req;
    beat    = (state == GRANT) & gnt[owner]
            & bus.req[owner] & bus.ready;
    rel     = (state == GRANT)
            & (~bus.req[owner]
               | (beat & (cnt == WW'(1))));
    // A releasing owner drops to lowest priority immediately.
    base    = rel ? next_o : ptr;
    sel     = pick(bus.req, base);
    wsel    = bus.weight[int'(sel)*WW +: WW];
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    valid_nx = valid;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx      = GRANT;
          owner_nx      = sel;
          gnt_nx        = '0;
          gnt_nx[sel]   = 1'b1;
          valid_nx      = 1'b1;
          cnt_nx        = (wsel == '0) ? WW'(1) : wsel;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nx = next_o;
          if (any_req) begin
            owner_nx    = sel;
            gnt_nx      = '0;
            gnt_nx[sel] = 1'b1;
            valid_nx    = 1'b1;
            cnt_nx      = (wsel == '0) ? WW'(1) : wsel;
          end else begin
            state_nx = IDLE;
            owner_nx = '0;
            gnt_nx   = '0;
            valid_nx = 1'b0;
            cnt_nx   = '0;
          end
        end else if (beat) begin
          cnt_nx = cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      gnt   <= gnt_nx;
      valid <= valid_nx;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_valid = valid;
  assign bus.gnt_idx   = owner;

  a_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(gnt)
  );

  a_idx: assert property (
    @(posedge clk) disable iff (rst)
    valid |-> gnt[owner]
  );
endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter (N=4, WW=3).
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_wrr_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  wrr_arbiter_if #(.N(4), .WW(3)) bus ();

  wrr_arbiter #(.N(4), .WW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic expect_gnt(
    input string    tag,
    input logic [3:0] g
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) idx = 2'(i);
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'(|g));
    check({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
  endtask

  logic [3:0] seq3 [11];

  initial begin
    n_cmp = 0;
    n_err = 0;
    seq3 = '{4'b0001, 4'b0010, 4'b0010, 4'b0100,
             4'b0100, 4'b0100, 4'b1000, 4'b0001,
             4'b0010, 4'b0010, 4'b0100};

    // 1: reset with all requests asserted
    rst        = 1'b1;
    bus.req    = 4'b1111;
    bus.weight = {3'd1, 3'd1, 3'd1, 3'd1};
    bus.ready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_gnt("t1_rst", 4'b0000);
    end

    // 2: sole requester holds grant continuously
    rst        = 1'b0;
    bus.req    = 4'b0010;
    bus.weight = {3'd2, 3'd2, 3'd2, 3'd2};
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_gnt("t2_sole", 4'b0010);
    end

    // 3: weighted rotation, no gaps
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    bus.req    = 4'b1111;
    bus.weight = {3'd1, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < 11; i++) begin
      tick();
      expect_gnt($sformatf("t3_seq%0d", i), seq3[i]);
    end
    check("t3_cnt", 32'(dut.cnt), 32'd3);

    // 4: backpressure freezes owner and credit
    bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_gnt("t4_hold", 4'b0100);
      check("t4_cnt", 32'(dut.cnt), 32'd3);
      check("t4_ptr", 32'(dut.ptr), 32'd2);
    end
    bus.ready = 1'b1;
    tick();
    expect_gnt("t4_b1", 4'b0100);
    check("t4_cnt1", 32'(dut.cnt), 32'd2);
    tick();
    expect_gnt("t4_b2", 4'b0100);
    check("t4_cnt2", 32'(dut.cnt), 32'd1);
    tick();
    expect_gnt("t4_b3", 4'b1000);
    check("t4_ptr3", 32'(dut.ptr), 32'd3);

    // 5: owner drops mid-burst, then wrap 3 -> 0
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    bus.req    = 4'b0010;
    bus.weight = {3'd2, 3'd1, 3'd4, 3'd1};
    tick();
    expect_gnt("t5_load", 4'b0010);
    check("t5_cnt0", 32'(dut.cnt), 32'd4);
    tick();
    expect_gnt("t5_beat", 4'b0010);
    check("t5_cnt1", 32'(dut.cnt), 32'd3);
    bus.req = 4'b1001;
    tick();
    expect_gnt("t5_drop", 4'b1000);
    check("t5_cnt3", 32'(dut.cnt), 32'd2);
    check("t5_ptr", 32'(dut.ptr), 32'd2);
    tick();
    expect_gnt("t5_own3", 4'b1000);
    tick();
    expect_gnt("t5_wrap", 4'b0001);
    check("t5_ptr0", 32'(dut.ptr), 32'd0);
    bus.req = 4'b0000;
    tick();
    expect_gnt("t5_idle", 4'b0000);
    tick();
    expect_gnt("t5_idle2", 4'b0000);

    // 6: zero weight acts as one; reset mid-burst
    bus.weight = {3'd1, 3'd1, 3'd1, 3'd0};
    bus.req    = 4'b0001;
    tick();
    expect_gnt("t6_load", 4'b0001);
    check("t6_cnt", 32'(dut.cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_gnt("t6_regnt", 4'b0001);
      check("t6_cnt_r", 32'(dut.cnt), 32'd1);
      check("t6_ptr_r", 32'(dut.ptr), 32'd1);
    end
    rst = 1'b1;
    tick();
    expect_gnt("t6_rst", 4'b0000);
    check("t6_ptr_rst", 32'(dut.ptr), 32'd0);
    check("t6_cnt_rst", 32'(dut.cnt), 32'd0);
    rst = 1'b0;
    tick();
    expect_gnt("t6_after", 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
